// File: rtl/add_seq_pkg.sv
// ============================================================================
// add_seq_pkg : shared constants and state type for the sequential adder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/multiword_adder_seq_rca4_slice.sv
// ============================================================================
// rca4_slice : combinational 4-bit ripple-carry adder slice
// Optional   : ADD_SEQ_OVERFLOW_EN exposes c3, the carry into the slice MSB
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca4_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
`ifdef ADD_SEQ_OVERFLOW_EN
    output logic               c3,
`endif
    output logic               cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
`ifdef ADD_SEQ_OVERFLOW_EN
        c3    = 1'b0;
`endif
        for (int i = 0; i < SLICE_W; i++) begin
`ifdef ADD_SEQ_OVERFLOW_EN
            if (i == SLICE_W - 1) c3 = carry;
`endif
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

`default_nettype wire

// File: rtl/multiword_adder_seq.sv
// ============================================================================
// multiword_adder_seq : WIDTH-bit adder time-multiplexed over one 4-bit slice
// Optional            : ADD_SEQ_OVERFLOW_EN adds the signed-overflow output ovf
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_adder_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADD_SEQ_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDXW   = $clog2(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t             state;
    logic [IDXW-1:0]    idx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_a = a_r[int'(idx) * SLICE_W +: SLICE_W];
    assign slice_b = b_r[int'(idx) * SLICE_W +: SLICE_W];

`ifdef ADD_SEQ_OVERFLOW_EN
    logic slice_c3;
`endif

    rca4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .sum  (slice_sum),
`ifdef ADD_SEQ_OVERFLOW_EN
        .c3   (slice_c3),
`endif
        .cout (slice_cout)
    );

    // Handshake outputs depend on the state register only
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef ADD_SEQ_OVERFLOW_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx) * SLICE_W +: SLICE_W] <= slice_sum;
                    carry_r <= slice_cout;
                    if (idx == LAST_IDX) begin
                        cout  <= slice_cout;
`ifdef ADD_SEQ_OVERFLOW_EN
                        ovf   <= slice_c3 ^ slice_cout;
`endif
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiword_adder_seq.sv
// ============================================================================
// tb_multiword_adder_seq : scoreboard bench with directed and random operands
// Revision               : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_adder_seq;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADD_SEQ_OVERFLOW_EN
    logic             ovf;
`endif

    multiword_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef ADD_SEQ_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t q[$];
    int   acc_q[$];
    int   cyc        = 0;
    int   last_acc   = -100;
    int   total      = 0;
    int   bad        = 0;
    bit   b2b_mode   = 0;
    bit   rand_ready = 0;
    logic prev_valid = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands
    function automatic exp_t model(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv, logic cv);
        exp_t        e;
        logic [16:0] full;
        int          s;
        full   = {1'b0, av} + {1'b0, bv} + 17'(cv);
        s      = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (s > 32767) || (s < -32768);
        return e;
    endfunction

    // Accept observer: pushes the expected response on every handshake
    always @(posedge clk) begin
        cyc++;
        if (!reset && in_valid && in_ready) begin
            if (b2b_mode) check("accept_spacing", 32'(cyc - last_acc), NSLICE + 2);
            last_acc = cyc;
            q.push_back(model(a, b, cin));
            acc_q.push_back(cyc);
        end
    end

    // Output monitor: compares every cycle the result is presented
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) check("in_ready_during_done", {31'b0, in_ready}, 0);
            if (out_valid && q.size() == 0) check("unexpected_valid", {31'b0, out_valid}, 0);
            if (out_valid && q.size() > 0) begin
                if (!prev_valid) check("latency", 32'(cyc - acc_q[0]), NSLICE);
                check("sum",  {16'b0, sum},   {16'b0, q[0].sum});
                check("cout", {31'b0, cout},  {31'b0, q[0].cout});
`ifdef ADD_SEQ_OVERFLOW_EN
                check("ovf",  {31'b0, ovf},   {31'b0, q[0].ovf});
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv, logic cv);
        int n = 0;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum",       {16'b0, sum},       0);
        check("rst_cout",      {31'b0, cout},      0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_in_ready",  {31'b0, in_ready},  1);
        reset = 1'b0;
        @(posedge clk); #1;

        send(16'h1234, 16'h4321, 1'b0); drain();
        send(16'hFFFF, 16'h0000, 1'b1); drain();

        // Consumer stall with a competing request that must wait
        out_ready = 1'b0;
        send(16'hA5A5, 16'h5A5A, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("stall_valid_timeout", {31'b0, out_valid}, 1);
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        send(16'h1111, 16'h2222, 1'b0); drain();

        // Reset mid-RUN aborts the operation
        send(16'h8000, 16'h8000, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b1;
        #1;
        q.delete(); acc_q.delete();
        check("abort_sum",       {16'b0, sum},       0);
        check("abort_out_valid", {31'b0, out_valid}, 0);
        check("abort_in_ready",  {31'b0, in_ready},  1);
        @(posedge clk);
        #1 reset = 1'b0;
        send(16'h0001, 16'h0001, 1'b0); drain();

        send(16'h1000, 16'h0FFF, 1'b0);
        b2b_mode = 1;
        send(16'hFFFF, 16'h0001, 1'b0);
        drain();
        b2b_mode = 0;

        send(16'h7FFF, 16'h0001, 1'b0); drain();
        send(16'hFFFF, 16'h0001, 1'b0); drain();
        send(16'h8000, 16'hFFFF, 1'b1); drain();

        rand_ready = 1;
        for (int i = 0; i < 40; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        rand_ready = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
